rob_commit: RTL
===============

# rob_commit

In-order reorder buffer and commit stage that sits directly downstream of the execute stage. It allocates entries for up to two dispatched instructions per cycle and absorbs the two execute-to-commit result buses. It retires up to two completed instructions per cycle in program order, gates store commit through the store handshake, and raises a pipeline flush on the oldest excepting instruction.

## Interface
- ROB_DEPTH, 16, number of entries; power of two, at least 4
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dispatch_valid  in  2  per-slot allocate request; slot 0 is older
- dispatch_info  in  2×rob_dispatch_t  pc, is_store, dest arch reg, new preg, old preg
- rob_allowin  out  1  high when at least 2 entries are free
- alloc_idx  out  2×$clog2(ROB_DEPTH)  index assigned to slot 0 and slot 1 this cycle
- execute_to_commit_bus1/2  in  execute_to_commit_bus_t  valid, rob_idx, result, exception, exccode
- commit_store_valid  out  1  head entry is a completed, non-excepting store
- commit_store_ready  in  1  store accepted by the memory side this cycle
- retire_valid  out  2  per-slot retire strobe; slot 0 is older
- retire_bus  out  2×retire_t  dest arch reg, new preg, old preg, result
- flush  out  1  one-cycle pipeline flush
- flush_epc  out  32  pc of the excepting instruction
- flush_exccode  out  5  exccode of the excepting instruction

## Operation
- State:
  - head and tail pointers, each $clog2(ROB_DEPTH)+1 bits; the MSB is the wrap bit.
  - Per entry: valid, done, exception, exccode, result, plus the dispatch_info fields.
- Occupancy and full/empty:
  - count = tail − head, modulo 2^(W+1).
  - Empty when head == tail; full when the indices match and the wrap bits differ.
  - rob_allowin = (ROB_DEPTH − count) ≥ 2. It is computed from registered state only.
- Allocation, when rob_allowin && !flush:
  - alloc_idx[0] = tail[W−1:0]; alloc_idx[1] = tail+1 (index bits).
  - A valid slot writes its entry with valid=1 and done=0.
  - tail advances by popcount(dispatch_valid). If only slot 1 is valid, it takes alloc_idx[0].
  - Dispatch while !rob_allowin is ignored.
- Writeback:
  - For each execute bus with valid set and entry[rob_idx].valid set: write done=1, result, exception and exccode.
  - A writeback to an entry that is not valid is dropped.
  - If both buses target the same index, bus1 wins.
- Retire of slot 0 (head entry valid and done):
  - exception=1: flush=1, flush_epc=pc, flush_exccode=exccode, retire_valid=0.
  - is_store=1: commit_store_valid=1. It retires (retire_valid[0]=1) only in a cycle with commit_store_ready=1. Otherwise it holds with no retire.
  - Any other case: retire_valid[0]=1.
- Retire of slot 1: only when slot 0 retired as a non-store, and head+1 is valid, done, not excepting and not a store.
- Retirement clears the valid bit of each retired entry; head advances by the retire count.
- Flush:
  - On the next edge every valid bit is cleared and head = tail = 0.
  - Allocation and writeback in the flush cycle are discarded.
- Reset:
  - head = tail = 0 and all valid bits = 0.
  - Outputs after reset: flush=0, commit_store_valid=0, retire_valid=0, rob_allowin=1, alloc_idx={0,1}.
  - retire_bus, flush_epc and flush_exccode = 0.

## Timing
- Dispatch in cycle N → the entry is visible in cycle N+1.
- Writeback in cycle N → retire is possible in cycle N+1 at the earliest. There is no same-cycle writeback-to-retire bypass.
- All retire, commit_store_valid and flush outputs are combinational from registered state plus commit_store_ready. They have no combinational path from dispatch or execute inputs.
- Best-case latency: dispatch at N, writeback at N+1, retire at N+2.
- commit_store_valid stays asserted until the cycle with commit_store_ready. Store and retire complete in the same cycle as ready.
- flush is high for exactly one cycle per exception, unless the next head also excepts.
- Simultaneous retire of 2 and allocate of 2 when full minus 2 is legal: rob_allowin uses pre-retire count, so this is conservative.
- Pointer wrap past ROB_DEPTH−1 toggles the wrap bit. Dual allocation across the wrap boundary must use correct modulo indices.

## Structure
- rob_dispatch_t, retire_t and the ROB_IDX_W constant go in the shared cpu package.
- The execute_to_commit_bus_t fields listed above also go in the shared cpu package.
- Single module, no sub-modules. Entry storage is a flop array, since writeback needs 2 write ports plus 2 dispatch write ports.

## Test plan
- Reset, then dispatch 2 non-store ops (idx 0,1) and write back both via bus1/bus2 next cycle → retire_valid=2'b11 two cycles after dispatch; head=2.
- Write back idx1 before idx0 → no retire until idx0 is done; then both retire in the same cycle, in order.
- Store at head done, commit_store_ready held 0 for 3 cycles then 1 → commit_store_valid high for 4 cycles, retire_valid[0] only in cycle 4, slot 1 never co-retires.
- Exception at idx 3 with pc=0x80001000, exccode=4 → flush high 1 cycle, flush_epc=0x80001000, flush_exccode=4, no retire. Next cycle: rob_allowin=1, alloc_idx={0,1}.
- Fill 15 of 16 entries → rob_allowin=0; a dispatch is ignored and tail is unchanged. Retire 1 → rob_allowin=1 next cycle.
- Run 40 single-op dispatch/retire iterations → pointers wrap twice, and alloc_idx across 15→0 is {15,0} for a dual dispatch.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg
//   Shared CPU types for the reorder buffer and its neighbours.
//   - rob_dispatch_t          : what dispatch hands the ROB for each new entry
//   - retire_t                : what the ROB reports for each retired entry
//   - execute_to_commit_bus_t : one execute-stage result bus into commit
//   ROB_IDX_W is the ROB index width used on the execute result buses.
package rob_commit_pkg;

  localparam int ROB_DEPTH_DEF = 16;
  localparam int ROB_IDX_W     = $clog2(ROB_DEPTH_DEF);
  localparam int XLEN          = 32;
  localparam int AREG_W        = 5;
  localparam int PREG_W        = 6;
  localparam int EXCCODE_W     = 5;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic              is_store;
    logic [AREG_W-1:0] dest_areg;
    logic [PREG_W-1:0] new_preg;
    logic [PREG_W-1:0] old_preg;
  } rob_dispatch_t;

  typedef struct packed {
    logic [AREG_W-1:0] dest_areg;
    logic [PREG_W-1:0] new_preg;
    logic [PREG_W-1:0] old_preg;
    logic [XLEN-1:0]   result;
  } retire_t;

  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      result;
    logic                 exception;
    logic [EXCCODE_W-1:0] exccode;
  } execute_to_commit_bus_t;

  // Number of set bits in a two-slot strobe (0, 1 or 2).
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/rob_commit.sv
// rob_commit
//   In-order reorder buffer plus commit stage. Allocates up to two entries
//   per cycle, absorbs two execute result buses, retires up to two completed
//   entries per cycle in program order, holds a store at the head until the
//   memory side accepts it, and raises a one-cycle flush for the oldest
//   excepting instruction.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   dispatch_valid[1:0]        allocate request per slot (slot 0 older)
//   dispatch_info[1:0]         payload for each dispatch slot
//   rob_allowin                at least two entries are free
//   alloc_idx[1:0]             entry indices offered to slot 0 / slot 1
//   execute_to_commit_bus1/2   result writeback buses (bus1 wins on a tie)
//   commit_store_valid         head is a completed, non-excepting store
//   commit_store_ready         memory side accepts that store this cycle
//   retire_valid[1:0]          retire strobe per slot (slot 0 older)
//   retire_bus[1:0]            architectural effects of retired entries
//   flush, flush_epc,
//   flush_exccode              one-cycle flush with pc/exccode of the culprit
module rob_commit
  import rob_commit_pkg::*;
#(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [1:0]                           dispatch_valid,
  input  rob_dispatch_t [1:0]                  dispatch_info,
  output logic                                 rob_allowin,
  output logic [1:0][$clog2(ROB_DEPTH)-1:0]    alloc_idx,
  input  execute_to_commit_bus_t               execute_to_commit_bus1,
  input  execute_to_commit_bus_t               execute_to_commit_bus2,
  output logic                                 commit_store_valid,
  input  logic                                 commit_store_ready,
  output logic [1:0]                           retire_valid,
  output retire_t [1:0]                        retire_bus,
  output logic                                 flush,
  output logic [XLEN-1:0]                      flush_epc,
  output logic [EXCCODE_W-1:0]                 flush_exccode
);

  localparam int W = $clog2(ROB_DEPTH);

  typedef logic [W:0]   ptr_t;
  typedef logic [W-1:0] idx_t;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  ptr_t head_q;
  ptr_t tail_q;
  ptr_t count;

  // Entry storage. Only the valid bits need a reset; every other field is
  // written before it can be observed.
  logic [ROB_DEPTH-1:0] valid_q;
  logic [ROB_DEPTH-1:0] done_q;
  logic [ROB_DEPTH-1:0] exc_q;
  logic [EXCCODE_W-1:0] exccode_q [ROB_DEPTH];
  logic [XLEN-1:0]      result_q  [ROB_DEPTH];
  rob_dispatch_t        info_q    [ROB_DEPTH];

  idx_t       head_idx0;
  idx_t       head_idx1;
  idx_t       slot1_idx;
  idx_t       wb1_idx;
  idx_t       wb2_idx;
  logic       do_alloc;
  logic       head0_ready;
  logic       head0_store;
  logic       head1_simple;
  logic [1:0] retire_count;
  logic [1:0] dispatch_count;

  // Occupancy and allocation offers come from registered pointers only, so
  // rob_allowin is based on the pre-retire count and is deliberately
  // conservative when a retire and an allocate land in the same cycle.
  always_comb begin
    count          = tail_q - head_q;
    rob_allowin    = (count <= ptr_t'(ROB_DEPTH - 2));
    alloc_idx[0]   = tail_q[W-1:0];
    alloc_idx[1]   = tail_q[W-1:0] + idx_t'(1);
    do_alloc       = rob_allowin & ~flush;
    dispatch_count = popcount2(dispatch_valid);
    // A lone slot-1 dispatch still takes the first free entry.
    slot1_idx      = dispatch_valid[0] ? alloc_idx[1] : alloc_idx[0];
    wb1_idx        = idx_t'(execute_to_commit_bus1.rob_idx);
    wb2_idx        = idx_t'(execute_to_commit_bus2.rob_idx);
  end

  // Commit decision for the two oldest entries. Everything here reads
  // registered state plus commit_store_ready, so a result written back this
  // cycle cannot retire until the next one.
  always_comb begin
    head_idx0          = head_q[W-1:0];
    head_idx1          = head_q[W-1:0] + idx_t'(1);
    head0_ready        = valid_q[head_idx0] & done_q[head_idx0];
    head0_store        = info_q[head_idx0].is_store;
    head1_simple       = valid_q[head_idx1] & done_q[head_idx1] &
                         ~exc_q[head_idx1] & ~info_q[head_idx1].is_store;

    flush              = head0_ready & exc_q[head_idx0];
    commit_store_valid = head0_ready & ~exc_q[head_idx0] & head0_store;
    retire_valid[0]    = head0_ready & ~exc_q[head_idx0] &
                         (~head0_store | commit_store_ready);
    // The second slot only rides along behind a plain (non-store) retire,
    // which keeps at most one store per cycle on the memory handshake.
    retire_valid[1]    = retire_valid[0] & ~head0_store & head1_simple;
    retire_count       = popcount2(retire_valid);
  end

  // Retire and flush payloads are zeroed when not asserted so downstream
  // logic never sees stale entry contents.
  always_comb begin
    retire_bus    = '0;
    flush_epc     = '0;
    flush_exccode = '0;
    if (retire_valid[0]) begin
      retire_bus[0].dest_areg = info_q[head_idx0].dest_areg;
      retire_bus[0].new_preg  = info_q[head_idx0].new_preg;
      retire_bus[0].old_preg  = info_q[head_idx0].old_preg;
      retire_bus[0].result    = result_q[head_idx0];
    end
    if (retire_valid[1]) begin
      retire_bus[1].dest_areg = info_q[head_idx1].dest_areg;
      retire_bus[1].new_preg  = info_q[head_idx1].new_preg;
      retire_bus[1].old_preg  = info_q[head_idx1].old_preg;
      retire_bus[1].result    = result_q[head_idx1];
    end
    if (flush) begin
      flush_epc     = info_q[head_idx0].pc;
      flush_exccode = exccode_q[head_idx0];
    end
  end

  // Pointers and valid bits. A flush empties the buffer and rewinds both
  // pointers, discarding any allocation requested in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
    end else begin
      head_q <= head_q + ptr_t'(retire_count);
      if (retire_valid[0]) valid_q[head_idx0] <= 1'b0;
      if (retire_valid[1]) valid_q[head_idx1] <= 1'b0;
      if (do_alloc) begin
        tail_q <= tail_q + ptr_t'(dispatch_count);
        if (dispatch_valid[0]) valid_q[alloc_idx[0]] <= 1'b1;
        if (dispatch_valid[1]) valid_q[slot1_idx]    <= 1'b1;
      end
    end
  end

  // Entry payload: two dispatch write ports and two writeback ports.
  // Allocation targets free entries and writeback only lands on valid ones,
  // so the two groups never collide. Bus2 is applied first so bus1 takes
  // precedence when both name the same entry.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      if (do_alloc && dispatch_valid[0]) begin
        info_q[alloc_idx[0]] <= dispatch_info[0];
        done_q[alloc_idx[0]] <= 1'b0;
      end
      if (do_alloc && dispatch_valid[1]) begin
        info_q[slot1_idx] <= dispatch_info[1];
        done_q[slot1_idx] <= 1'b0;
      end
      if (execute_to_commit_bus2.valid && valid_q[wb2_idx]) begin
        done_q[wb2_idx]    <= 1'b1;
        exc_q[wb2_idx]     <= execute_to_commit_bus2.exception;
        exccode_q[wb2_idx] <= execute_to_commit_bus2.exccode;
        result_q[wb2_idx]  <= execute_to_commit_bus2.result;
      end
      if (execute_to_commit_bus1.valid && valid_q[wb1_idx]) begin
        done_q[wb1_idx]    <= 1'b1;
        exc_q[wb1_idx]     <= execute_to_commit_bus1.exception;
        exccode_q[wb1_idx] <= execute_to_commit_bus1.exccode;
        result_q[wb1_idx]  <= execute_to_commit_bus1.result;
      end
    end
  end

endmodule
